ahb_xip_slave_ctrl: RTL and testbench

AHB_XIP_SLAVE_CTRL -- requirements
Module: ahb_xip_slave_ctrl

---
 rtl/ahb_xip_slave_ctrl.sv | 158 +++++++++++++++
 tb/tb_ahb_xip_slave_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_xip_slave_ctrl.sv
// AHB slave control FSM for execute-in-place reads: starts QSPI fetches,
// stalls HREADY until read data arrives, and produces two-cycle ERROR responses.
module ahb_xip_slave_ctrl (
  input  logic       h_clk,
  input  logic       h_rstn,
  input  logic       h_sel,
  input  logic       non_seq_in,
  input  logic       seq_in,
  input  logic       idle_in,
  input  logic       busy_in,
  input  logic       h_write,
  input  logic [2:0] h_burst_in,
  input  logic       enter_xip_mode_in,
  input  logic       addr_err_in,
  input  logic       rd_valid_in,
  output logic       rd_pop_out,
  output logic       xip_start_out,
  output logic [4:0] xip_len_out,
  output logic       xip_abort_out,
  output logic       load_h_addr_out,
  output logic       load_h_burst_out,
  output logic       h_ready_out,
  output logic       h_resp_err_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DATA  = 3'd2,
    S_NEXT  = 3'd3,
    S_ABORT = 3'd4,
    S_ERR1  = 3'd5,
    S_ERR2  = 3'd6
  } state_t;

  localparam logic [2:0] BURST_INCR = 3'b001;
  localparam logic [7:0] WD_LAST    = 8'd254;

  state_t     state_q, state_d;
  logic [4:0] len_q, len_d;
  logic [4:0] beats_left_q, beats_left_d;
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       err_flag_q, err_flag_d;

  logic [4:0] burst_len;
  logic       xfer_req;
  logic       start_ok;

  // WRAPx and INCRx share a length; SINGLE and INCR fetch one word at a time.
  always_comb begin
    case (h_burst_in[2:1])
      2'b00:   burst_len = 5'd1;
      2'b01:   burst_len = 5'd4;
      2'b10:   burst_len = 5'd8;
      default: burst_len = 5'd16;
    endcase
  end

  assign xfer_req = h_sel & (non_seq_in | seq_in);
  // An undefined-length INCR burst restarts a single-word fetch on every SEQ beat.
  assign start_ok = h_rstn & h_sel & enter_xip_mode_in & ~h_write &
                    (non_seq_in | (seq_in & (h_burst_in == BURST_INCR)));

  always_comb begin
    state_d          = state_q;
    len_d            = len_q;
    beats_left_d     = beats_left_q;
    wd_cnt_d         = wd_cnt_q;
    err_flag_d       = err_flag_q;
    h_ready_out      = 1'b1;
    h_resp_err_out   = 1'b0;
    xip_start_out    = 1'b0;
    xip_abort_out    = 1'b0;
    rd_pop_out       = 1'b0;
    load_h_addr_out  = 1'b0;
    load_h_burst_out = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (xfer_req && addr_err_in) begin
          state_d = S_ERR1;
        end else if (start_ok) begin
          xip_start_out    = 1'b1;
          load_h_addr_out  = 1'b1;
          load_h_burst_out = 1'b1;
          len_d            = burst_len;
          beats_left_d     = burst_len;
          wd_cnt_d         = 8'd0;
          err_flag_d       = 1'b0;
          state_d          = S_FETCH;
        end
      end
      S_FETCH: begin
        h_ready_out = 1'b0;
        wd_cnt_d    = wd_cnt_q + 8'd1;
        if (rd_valid_in) begin
          state_d = S_DATA;
        end else if (wd_cnt_q == WD_LAST) begin
          err_flag_d = 1'b1;
          state_d    = S_ABORT;
        end
      end
      S_DATA: begin
        rd_pop_out   = 1'b1;
        beats_left_d = beats_left_q - 5'd1;
        state_d      = (beats_left_q == 5'd1) ? S_IDLE : S_NEXT;
      end
      S_NEXT: begin
        if (h_sel && seq_in) begin
          wd_cnt_d = 8'd0;
          state_d  = S_FETCH;
        end else if (h_sel && busy_in && !idle_in && !non_seq_in) begin
          state_d = S_NEXT;
        end else begin
          err_flag_d = 1'b0;
          state_d    = S_ABORT;
        end
      end
      S_ABORT: begin
        // Stalling here keeps the master's pending address phase on the bus.
        h_ready_out   = 1'b0;
        xip_abort_out = 1'b1;
        state_d       = err_flag_q ? S_ERR2 : S_IDLE;
      end
      S_ERR1: begin
        h_ready_out    = 1'b0;
        h_resp_err_out = 1'b1;
        state_d        = S_ERR2;
      end
      S_ERR2: begin
        h_resp_err_out = 1'b1;
        err_flag_d     = 1'b0;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The QSPI side sees the new length together with the start pulse.
  assign xip_len_out = xip_start_out ? burst_len : len_q;

  always_ff @(posedge h_clk or negedge h_rstn) begin
    if (!h_rstn) begin
      state_q      <= S_IDLE;
      len_q        <= 5'd0;
      beats_left_q <= 5'd0;
      wd_cnt_q     <= 8'd0;
      err_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      beats_left_q <= beats_left_d;
      wd_cnt_q     <= wd_cnt_d;
      err_flag_q   <= err_flag_d;
    end
  end

endmodule

// File: tb/tb_ahb_xip_slave_ctrl.sv
// Directed bench for ahb_xip_slave_ctrl: a per-cycle vector table plus
// hand-written burst, abort, watchdog and reset sequences.
module tb_ahb_xip_slave_ctrl;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_BUSY = 2'd1;
  localparam logic [1:0] T_NSEQ = 2'd2;
  localparam logic [1:0] T_SEQ  = 2'd3;

  logic       h_clk = 1'b0;
  logic       h_rstn = 1'b0;
  logic       h_sel = 1'b0;
  logic       non_seq_in = 1'b0;
  logic       seq_in = 1'b0;
  logic       idle_in = 1'b1;
  logic       busy_in = 1'b0;
  logic       h_write = 1'b0;
  logic [2:0] h_burst_in = 3'd0;
  logic       enter_xip_mode_in = 1'b0;
  logic       addr_err_in = 1'b0;
  logic       rd_valid_in = 1'b0;
  logic       rd_pop_out;
  logic       xip_start_out;
  logic [4:0] xip_len_out;
  logic       xip_abort_out;
  logic       load_h_addr_out;
  logic       load_h_burst_out;
  logic       h_ready_out;
  logic       h_resp_err_out;

  always #5 h_clk = ~h_clk;

  ahb_xip_slave_ctrl dut (
    .h_clk             (h_clk),
    .h_rstn            (h_rstn),
    .h_sel             (h_sel),
    .non_seq_in        (non_seq_in),
    .seq_in            (seq_in),
    .idle_in           (idle_in),
    .busy_in           (busy_in),
    .h_write           (h_write),
    .h_burst_in        (h_burst_in),
    .enter_xip_mode_in (enter_xip_mode_in),
    .addr_err_in       (addr_err_in),
    .rd_valid_in       (rd_valid_in),
    .rd_pop_out        (rd_pop_out),
    .xip_start_out     (xip_start_out),
    .xip_len_out       (xip_len_out),
    .xip_abort_out     (xip_abort_out),
    .load_h_addr_out   (load_h_addr_out),
    .load_h_burst_out  (load_h_burst_out),
    .h_ready_out       (h_ready_out),
    .h_resp_err_out    (h_resp_err_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe counters, written only by the monitor below.
  int start_cnt = 0;
  int pop_cnt   = 0;
  int abort_cnt = 0;
  int excl_cnt  = 0;

  always @(negedge h_clk) begin
    start_cnt = start_cnt + int'(xip_start_out);
    pop_cnt   = pop_cnt + int'(rd_pop_out);
    abort_cnt = abort_cnt + int'(xip_abort_out);
    if ((int'(xip_start_out) + int'(rd_pop_out) + int'(xip_abort_out)) > 1)
      excl_cnt = excl_cnt + 1;
  end

  typedef struct {
    logic       sel;
    logic [1:0] tr;
    logic       wr;
    logic [2:0] burst;
    logic       xip;
    logic       aerr;
    logic       rdv;
    logic       rdy;
    logic       resp;
    logic       start;
    logic [4:0] len;
    logic       abort;
    logic       pop;
  } vec_t;

  vec_t tbl [31];

  function automatic vec_t mk(logic sel, logic [1:0] tr, logic wr, logic [2:0] burst,
                              logic xip, logic aerr, logic rdv, logic rdy, logic resp,
                              logic start, logic [4:0] len, logic abort, logic pop);
    vec_t v;
    v.sel = sel; v.tr = tr; v.wr = wr; v.burst = burst; v.xip = xip; v.aerr = aerr;
    v.rdv = rdv; v.rdy = rdy; v.resp = resp; v.start = start; v.len = len;
    v.abort = abort; v.pop = pop;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic sel, input logic [1:0] tr, input logic wr,
                        input logic [2:0] burst, input logic xip, input logic aerr,
                        input logic rdv);
    h_sel             = sel;
    idle_in           = (tr == T_IDLE);
    busy_in           = (tr == T_BUSY);
    non_seq_in        = (tr == T_NSEQ);
    seq_in            = (tr == T_SEQ);
    h_write           = wr;
    h_burst_in        = burst;
    enter_xip_mode_in = xip;
    addr_err_in       = aerr;
    rd_valid_in       = rdv;
  endtask

  // Apply inputs just after the rising edge, then move to the falling edge to sample.
  task automatic cyc(input logic sel, input logic [1:0] tr, input logic [2:0] burst,
                     input logic xip, input logic rdv);
    @(posedge h_clk);
    #1;
    set_in(sel, tr, 1'b0, burst, xip, 1'b0, rdv);
    @(negedge h_clk);
  endtask

  // FETCH for wait_cyc cycles (read data on the last one), then the DATA beat.
  task automatic fetch_data(input string tag, input int wait_cyc, input logic [1:0] tr_after);
    for (int k = 1; k <= wait_cyc; k++) begin
      cyc(1'b1, T_SEQ, 3'd0, 1'b1, (k == wait_cyc));
      chk({tag, ".fetch_rdy"}, h_ready_out, 1'b0);
    end
    cyc(1'b1, tr_after, 3'd0, 1'b1, 1'b0);
    chk({tag, ".pop"}, rd_pop_out, 1'b1);
    chk({tag, ".data_rdy"}, h_ready_out, 1'b1);
  endtask

  int s0, p0, a0;

  initial begin
    tbl[0]  = mk(0, T_IDLE, 0, 3'b000, 0, 0, 0,  1, 0, 0, 5'd0, 0, 0);
    tbl[1]  = mk(1, T_NSEQ, 1, 3'b000, 0, 0, 0,  1, 0, 0, 5'd0, 0, 0);
    tbl[2]  = mk(1, T_NSEQ, 0, 3'b000, 1, 0, 0,  1, 0, 1, 5'd1, 0, 0);
    tbl[3]  = mk(0, T_IDLE, 0, 3'b000, 0, 0, 0,  0, 0, 0, 5'd1, 0, 0);
    tbl[4]  = mk(0, T_IDLE, 0, 3'b000, 0, 0, 0,  0, 0, 0, 5'd1, 0, 0);
    tbl[5]  = mk(0, T_IDLE, 0, 3'b000, 0, 0, 0,  0, 0, 0, 5'd1, 0, 0);
    tbl[6]  = mk(0, T_IDLE, 0, 3'b000, 0, 0, 0,  0, 0, 0, 5'd1, 0, 0);
    tbl[7]  = mk(0, T_IDLE, 0, 3'b000, 0, 0, 0,  0, 0, 0, 5'd1, 0, 0);
    tbl[8]  = mk(0, T_IDLE, 0, 3'b000, 0, 0, 1,  0, 0, 0, 5'd1, 0, 0);
    tbl[9]  = mk(0, T_IDLE, 0, 3'b000, 0, 0, 0,  1, 0, 0, 5'd1, 0, 1);
    tbl[10] = mk(0, T_IDLE, 0, 3'b000, 0, 0, 0,  1, 0, 0, 5'd1, 0, 0);
    tbl[11] = mk(1, T_NSEQ, 0, 3'b000, 1, 1, 0,  1, 0, 0, 5'd1, 0, 0);
    tbl[12] = mk(0, T_IDLE, 0, 3'b000, 0, 0, 0,  0, 1, 0, 5'd1, 0, 0);
    tbl[13] = mk(0, T_IDLE, 0, 3'b000, 0, 0, 0,  1, 1, 0, 5'd1, 0, 0);
    tbl[14] = mk(0, T_IDLE, 0, 3'b000, 0, 0, 0,  1, 0, 0, 5'd1, 0, 0);
    tbl[15] = mk(1, T_SEQ,  0, 3'b001, 1, 1, 0,  1, 0, 0, 5'd1, 0, 0);
    tbl[16] = mk(0, T_IDLE, 0, 3'b000, 0, 0, 0,  0, 1, 0, 5'd1, 0, 0);
    tbl[17] = mk(0, T_IDLE, 0, 3'b000, 0, 0, 0,  1, 1, 0, 5'd1, 0, 0);
    tbl[18] = mk(1, T_SEQ,  0, 3'b001, 1, 0, 0,  1, 0, 1, 5'd1, 0, 0);
    tbl[19] = mk(0, T_IDLE, 0, 3'b000, 0, 0, 1,  0, 0, 0, 5'd1, 0, 0);
    tbl[20] = mk(0, T_IDLE, 0, 3'b000, 0, 0, 0,  1, 0, 0, 5'd1, 0, 1);
    tbl[21] = mk(0, T_IDLE, 0, 3'b000, 0, 0, 1,  1, 0, 0, 5'd1, 0, 0);
    tbl[22] = mk(1, T_BUSY, 0, 3'b001, 1, 0, 0,  1, 0, 0, 5'd1, 0, 0);
    tbl[23] = mk(1, T_SEQ,  0, 3'b011, 1, 0, 0,  1, 0, 0, 5'd1, 0, 0);
    tbl[24] = mk(0, T_NSEQ, 0, 3'b000, 1, 0, 0,  1, 0, 0, 5'd1, 0, 0);
    tbl[25] = mk(1, T_NSEQ, 0, 3'b100, 1, 0, 0,  1, 0, 1, 5'd8, 0, 0);
    tbl[26] = mk(0, T_IDLE, 0, 3'b000, 0, 0, 1,  0, 0, 0, 5'd8, 0, 0);
    tbl[27] = mk(0, T_IDLE, 0, 3'b000, 0, 0, 0,  1, 0, 0, 5'd8, 0, 1);
    tbl[28] = mk(0, T_IDLE, 0, 3'b000, 0, 0, 0,  1, 0, 0, 5'd8, 0, 0);
    tbl[29] = mk(0, T_IDLE, 0, 3'b000, 0, 0, 0,  0, 0, 0, 5'd8, 1, 0);
    tbl[30] = mk(0, T_IDLE, 0, 3'b000, 0, 0, 0,  1, 0, 0, 5'd8, 0, 0);

    // Reset state, with a start-eligible request on the bus.
    set_in(1'b1, T_NSEQ, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
    #2;
    chk("rst.rdy", h_ready_out, 1'b1);
    chk("rst.resp", h_resp_err_out, 1'b0);
    chk("rst.start", xip_start_out, 1'b0);
    chk("rst.len", xip_len_out, 5'd0);
    chk("rst.pop", rd_pop_out, 1'b0);
    chk("rst.ldaddr", load_h_addr_out, 1'b0);
    repeat (3) @(posedge h_clk);
    #1;
    set_in(1'b0, T_IDLE, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    h_rstn = 1'b1;

    for (int i = 0; i < 31; i++) begin
      @(posedge h_clk);
      #1;
      set_in(tbl[i].sel, tbl[i].tr, tbl[i].wr, tbl[i].burst, tbl[i].xip, tbl[i].aerr, tbl[i].rdv);
      @(negedge h_clk);
      chk($sformatf("v%0d.rdy", i), h_ready_out, tbl[i].rdy);
      chk($sformatf("v%0d.resp", i), h_resp_err_out, tbl[i].resp);
      chk($sformatf("v%0d.start", i), xip_start_out, tbl[i].start);
      chk($sformatf("v%0d.ldaddr", i), load_h_addr_out, tbl[i].start);
      chk($sformatf("v%0d.ldburst", i), load_h_burst_out, tbl[i].start);
      chk($sformatf("v%0d.len", i), xip_len_out, tbl[i].len);
      chk($sformatf("v%0d.abort", i), xip_abort_out, tbl[i].abort);
      chk($sformatf("v%0d.pop", i), rd_pop_out, tbl[i].pop);
      $display("vec %0d: rdy=%b resp=%b start=%b len=%0d abort=%b pop=%b", i,
               h_ready_out, h_resp_err_out, xip_start_out, xip_len_out, xip_abort_out, rd_pop_out);
    end

    // INCR4, four SEQ beats, read data every third cycle.
    s0 = start_cnt; p0 = pop_cnt; a0 = abort_cnt;
    cyc(1'b1, T_NSEQ, 3'b011, 1'b1, 1'b0);
    chk("incr4.start", xip_start_out, 1'b1);
    chk("incr4.len", xip_len_out, 5'd4);
    for (int b = 0; b < 4; b++) begin
      fetch_data($sformatf("incr4.b%0d", b), 3, (b == 3) ? T_IDLE : T_SEQ);
      if (b < 3) begin
        cyc(1'b1, T_SEQ, 3'b011, 1'b1, 1'b0);
        chk("incr4.next_rdy", h_ready_out, 1'b1);
      end
    end
    cyc(1'b0, T_IDLE, 3'b000, 1'b0, 1'b0);
    chk("incr4.idle_rdy", h_ready_out, 1'b1);
    chk("incr4.len_hold", xip_len_out, 5'd4);
    chk("incr4.n_start", start_cnt - s0, 1);
    chk("incr4.n_pop", pop_cnt - p0, 4);
    chk("incr4.n_abort", abort_cnt - a0, 0);
    $display("seq incr4: starts=%0d pops=%0d aborts=%0d", start_cnt - s0, pop_cnt - p0, abort_cnt - a0);

    // INCR8 with a BUSY pause, ended by IDLE after the third beat.
    s0 = start_cnt; p0 = pop_cnt; a0 = abort_cnt;
    cyc(1'b1, T_NSEQ, 3'b101, 1'b1, 1'b0);
    chk("incr8.len", xip_len_out, 5'd8);
    fetch_data("incr8.b0", 2, T_SEQ);
    repeat (2) begin
      cyc(1'b1, T_BUSY, 3'b101, 1'b1, 1'b0);
      chk("incr8.busy_rdy", h_ready_out, 1'b1);
      chk("incr8.busy_abort", xip_abort_out, 1'b0);
    end
    cyc(1'b1, T_SEQ, 3'b101, 1'b1, 1'b0);
    fetch_data("incr8.b1", 2, T_SEQ);
    cyc(1'b1, T_SEQ, 3'b101, 1'b1, 1'b0);
    fetch_data("incr8.b2", 2, T_SEQ);
    cyc(1'b1, T_IDLE, 3'b101, 1'b0, 1'b0);
    chk("incr8.next_rdy", h_ready_out, 1'b1);
    cyc(1'b0, T_IDLE, 3'b000, 1'b0, 1'b0);
    chk("incr8.abort", xip_abort_out, 1'b1);
    chk("incr8.abort_rdy", h_ready_out, 1'b0);
    chk("incr8.abort_resp", h_resp_err_out, 1'b0);
    cyc(1'b0, T_IDLE, 3'b000, 1'b0, 1'b0);
    chk("incr8.idle_rdy", h_ready_out, 1'b1);
    chk("incr8.idle_resp", h_resp_err_out, 1'b0);
    cyc(1'b0, T_IDLE, 3'b000, 1'b0, 1'b0);
    chk("incr8.n_start", start_cnt - s0, 1);
    chk("incr8.n_pop", pop_cnt - p0, 3);
    chk("incr8.n_abort", abort_cnt - a0, 1);
    $display("seq incr8: starts=%0d pops=%0d aborts=%0d", start_cnt - s0, pop_cnt - p0, abort_cnt - a0);

    // Watchdog: 255 cycles of FETCH without read data.
    s0 = start_cnt; p0 = pop_cnt; a0 = abort_cnt;
    cyc(1'b1, T_NSEQ, 3'b000, 1'b1, 1'b0);
    chk("wd.start", xip_start_out, 1'b1);
    for (int k = 0; k < 255; k++) begin
      cyc(1'b0, T_IDLE, 3'b000, 1'b0, 1'b0);
      chk($sformatf("wd.rdy%0d", k), h_ready_out, 1'b0);
    end
    cyc(1'b0, T_IDLE, 3'b000, 1'b0, 1'b0);
    chk("wd.abort", xip_abort_out, 1'b1);
    chk("wd.abort_rdy", h_ready_out, 1'b0);
    chk("wd.abort_resp", h_resp_err_out, 1'b0);
    cyc(1'b0, T_IDLE, 3'b000, 1'b0, 1'b0);
    chk("wd.err2_rdy", h_ready_out, 1'b1);
    chk("wd.err2_resp", h_resp_err_out, 1'b1);
    cyc(1'b0, T_IDLE, 3'b000, 1'b0, 1'b0);
    chk("wd.idle_rdy", h_ready_out, 1'b1);
    chk("wd.idle_resp", h_resp_err_out, 1'b0);
    cyc(1'b0, T_IDLE, 3'b000, 1'b0, 1'b0);
    chk("wd.n_abort", abort_cnt - a0, 1);
    chk("wd.n_pop", pop_cnt - p0, 0);
    $display("seq watchdog: starts=%0d pops=%0d aborts=%0d", start_cnt - s0, pop_cnt - p0, abort_cnt - a0);

    // Asynchronous reset during FETCH of an INCR16, then a fresh SINGLE read.
    s0 = start_cnt; p0 = pop_cnt; a0 = abort_cnt;
    cyc(1'b1, T_NSEQ, 3'b111, 1'b1, 1'b0);
    chk("rst16.len", xip_len_out, 5'd16);
    repeat (3) begin
      cyc(1'b1, T_SEQ, 3'b111, 1'b1, 1'b0);
      chk("rst16.fetch_rdy", h_ready_out, 1'b0);
    end
    @(posedge h_clk);
    #1;
    set_in(1'b1, T_NSEQ, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
    #2;
    h_rstn = 1'b0;
    #1;
    chk("rst16.rdy", h_ready_out, 1'b1);
    chk("rst16.resp", h_resp_err_out, 1'b0);
    chk("rst16.len", xip_len_out, 5'd0);
    chk("rst16.start", xip_start_out, 1'b0);
    chk("rst16.abort", xip_abort_out, 1'b0);
    chk("rst16.pop", rd_pop_out, 1'b0);
    repeat (2) @(posedge h_clk);
    #1;
    chk("rst16.hold_rdy", h_ready_out, 1'b1);
    chk("rst16.hold_start", xip_start_out, 1'b0);
    set_in(1'b0, T_IDLE, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    h_rstn = 1'b1;
    cyc(1'b1, T_NSEQ, 3'b000, 1'b1, 1'b0);
    chk("rst16.new_start", xip_start_out, 1'b1);
    chk("rst16.new_len", xip_len_out, 5'd1);
    fetch_data("rst16.single", 2, T_IDLE);
    cyc(1'b0, T_IDLE, 3'b000, 1'b0, 1'b0);
    chk("rst16.idle_rdy", h_ready_out, 1'b1);
    cyc(1'b0, T_IDLE, 3'b000, 1'b0, 1'b0);
    chk("rst16.n_start", start_cnt - s0, 2);
    chk("rst16.n_pop", pop_cnt - p0, 1);
    chk("rst16.n_abort", abort_cnt - a0, 0);
    $display("seq reset: starts=%0d pops=%0d aborts=%0d", start_cnt - s0, pop_cnt - p0, abort_cnt - a0);

    chk("strobe_exclusive", excl_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
